uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue directly upstream of the uart transmitter. Accepts bytes from the system side into a
//  DEPTH-entry FIFO and issues them one at a time to the uart (start/txin), waiting for txdone per byte.
//  Decouples bursty producers from the fixed baud rate. Flags overflow and a stalled transmitter.
// PARAMETERS
//  DEPTH        16      FIFO entries; power of two, >=2
//  TIMEOUT_CYC  20000   max clk cycles to wait for txdone after start; >= 11*(clk_rate/baud_rate+1)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst        in   1              asynchronous, active-high reset
//  wr_en      in   1              push wr_data this cycle
//  wr_data    in   8              byte to queue
//  full       out  1              FIFO holds DEPTH entries
//  empty      out  1              FIFO holds 0 entries
//  level      out  $clog2(DEPTH)+1  current entry count
//  overflow   out  1              sticky: a push was dropped because full
//  tx_timeout out  1              sticky: txdone not seen within TIMEOUT_CYC
//  busy       out  1              a byte is in flight to the uart (LAUNCH or WAIT_DONE)
//  start      out  1              to uart.start; one-cycle pulse per byte
//  txin       out  8              to uart.txin; stable from start pulse until next start
//  txdone     in   1              from uart.txdone; one-cycle pulse at end of stop bit
// BEHAVIOUR
//  Reset (async, any time, incl. mid-byte): start=0, txin=0, busy=0, full=0, empty=1, level=0,
//   overflow=0, tx_timeout=0, state=IDLE, pointers=0, timeout counter=0. FIFO RAM not cleared.
//   In-flight byte is abandoned; the uart is not reset by this block.
//  FIFO: rd/wr pointers $clog2(DEPTH)+1 bits, wrap naturally; full/empty/level registered.
//   Push accepted iff wr_en && !full (registered full). wr_en && full -> byte dropped, overflow<=1.
//   Push and pop in same cycle: both take effect, level unchanged. Push while full is dropped even
//   if a pop occurs that cycle.
//  FSM states:
//   IDLE      : if !empty -> pop head: txin<=head, start<=1, rd_ptr++, -> LAUNCH. else stay, start=0.
//   LAUNCH    : start<=0, timer<=0, -> WAIT_DONE. (start high exactly one cycle.)
//   WAIT_DONE : txdone=1 -> IDLE. else timer++; timer==TIMEOUT_CYC-1 -> tx_timeout<=1, -> IDLE
//               (byte counted as lost, not re-queued).
//  busy = (state != IDLE).
//  Latency: wr_en at cycle N into empty FIFO, state IDLE -> empty=0 at N+1, start=1 at N+2.
//  Back-to-back: txdone at cycle M -> IDLE at M+1 -> next start at M+2 if !empty (uart is in its idle
//   state by then).
//  txdone while in IDLE or LAUNCH is ignored (no state or flag change).
//  Unused state encoding -> IDLE with start=0.
// STRUCTURE
//  uart_pkg: FIFO state encodings (Q_IDLE=0, Q_LAUNCH=1, Q_WAIT=2), BYTE_W=8.
//  Sub-module: uart_byte_fifo (sync FIFO: push/pop/full/empty/level/head data).
//  Top holds FSM, timeout counter, sticky flags, start/txin registers.
// TESTING
//  1 Reset: assert rst mid-WAIT_DONE -> all outputs to reset values same cycle, empty=1, start=0.
//  2 Single byte: push 0xA5 into empty queue -> start pulse 1 cycle at N+2, txin=0xA5; uart line
//    shows 0,1,0,1,0,0,1,0,1,1 (LSB first); txdone -> busy=0.
//  3 Burst: push 0x01..0x10 (DEPTH=16) back-to-back -> full=1 after 16th, level=16; all 16 bytes
//    leave in order; each start is 2 cycles after previous txdone; overflow stays 0.
//  4 Overflow: fill 16, push 0xFF while full -> dropped, overflow=1 sticky; 0xFF never transmitted.
//  5 Simultaneous push/pop: push on the cycle IDLE pops with level=3 -> level stays 3, order kept.
//  6 Timeout: tie txdone=0, push 0x55 -> after TIMEOUT_CYC cycles tx_timeout=1, busy=0, next byte issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the uart transmit queue:
// byte width and launch FSM state encodings.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] Q_IDLE   = 2'd0;
  localparam logic [1:0] Q_LAUNCH = 2'd1;
  localparam logic [1:0] Q_WAIT   = 2'd2;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/level
// and a combinational head-of-queue read port.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       data,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] L_FULL = LW'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       level_nx;
  logic              do_push;
  logic              do_pop;

  // Both gated by registered flags, so a full push is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_comb begin
    level_nx = level;
    unique case ({do_push, do_pop})
      2'b10:   level_nx = level + LW'(1);
      2'b01:   level_nx = level - LW'(1);
      default: level_nx = level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
      level <= level_nx;
      full  <= (level_nx == L_FULL);
      empty <= (level_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue upstream of the uart transmitter: pops one byte,
// pulses start, then waits for txdone or a stall timeout.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    tx_timeout,
  output logic                    busy,
  output logic                    start,
  output logic [BYTE_W-1:0]       txin,
  input  logic                    txdone
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]        state;
  logic [TW-1:0]     timer;
  logic [BYTE_W-1:0] head;
  logic              pop;

  assign pop  = (state == Q_IDLE) && !empty;
  assign busy = (state != Q_IDLE);

  uart_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_en),
    .data (wr_data),
    .pop  (pop),
    .head (head),
    .full (full),
    .empty(empty),
    .level(level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  // A timed-out byte is counted as lost; the FSM moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= Q_IDLE;
      timer      <= '0;
      start      <= 1'b0;
      txin       <= '0;
      tx_timeout <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (1'b1)
        (state == Q_IDLE): begin
          if (!empty) begin
            txin  <= head;
            start <= 1'b1;
            state <= Q_LAUNCH;
          end
        end
        (state == Q_LAUNCH): begin
          timer <= '0;
          state <= Q_WAIT;
        end
        (state == Q_WAIT): begin
          if (txdone) begin
            state <= Q_IDLE;
          end else if (timer == T_LAST) begin
            tx_timeout <= 1'b1;
            state      <= Q_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= Q_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: vector table, directed
// corner sequences and a randomized run against a queue model.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int TCYC  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       td_man = 1'b0;
  logic       td_uart = 1'b0;
  logic       txdone;
  logic       full, empty, overflow, tx_timeout, busy, start;
  logic [4:0] level;
  logic [7:0] txin;

  assign txdone = td_man | td_uart;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .tx_timeout(tx_timeout),
    .busy(busy),
    .start(start),
    .txin(txin),
    .txdone(txdone)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Uart stand-in: logs each launched byte, answers with txdone
  // after a 10-bit frame of bitc cycles per bit.
  logic       uart_on = 1'b0;
  logic       rand_mode = 1'b0;
  logic       gap_chk = 1'b0;
  logic       start_d = 1'b0;
  int         bitc = 3;
  int         cnt = 0;
  int         neg = 0;
  int         last_done = -100;
  logic [7:0] log_q[$];

  always @(negedge clk) begin
    neg++;
    td_uart = 1'b0;
    if (rst) begin
      cnt = 0;
      start_d = 1'b0;
    end else begin
      if (start) begin
        log_q.push_back(txin);
        chk("start_width", start_d, 0);
        if (gap_chk) chk("start_gap", neg - last_done, 2);
        if (rand_mode) bitc = $urandom_range(1, 3);
        cnt = uart_on ? 10 * bitc : 0;
        if (rand_mode && $urandom_range(0, 7) == 0) cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          td_uart = 1'b1;
          last_done = neg;
        end
      end else if (rand_mode && $urandom_range(0, 49) == 0) begin
        td_uart = 1'b1;
      end
      start_d = start;
    end
  end

  // Reference model: a byte queue plus "transmitter owned since
  // edge pop_e" with a deadline pop_e+TCYC+1.
  logic [7:0]  m_q[$];
  logic        m_busy = 1'b0;
  logic        m_start = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_to = 1'b0;
  logic [7:0]  m_txin = 8'h00;
  logic        m_full_now;
  int unsigned eidx = 0;
  int unsigned pop_e = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_start = 1'b0;
      m_ovf = 1'b0;
      m_to = 1'b0;
      m_txin = 8'h00;
    end else begin
      eidx++;
      m_full_now = (m_q.size() == DEPTH);
      m_start = 1'b0;
      if (m_busy && eidx >= pop_e + 2 && txdone) begin
        m_busy = 1'b0;
      end else if (m_busy && eidx == pop_e + TCYC + 1) begin
        m_busy = 1'b0;
        m_to = 1'b1;
      end else if (!m_busy && m_q.size() != 0) begin
        m_txin = m_q.pop_front();
        m_start = 1'b1;
        m_busy = 1'b1;
        pop_e = eidx;
      end
      if (wr_en) begin
        if (m_full_now) m_ovf = 1'b1;
        else m_q.push_back(wr_data);
      end
    end
  end

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       td;
    logic [4:0] lvl;
    logic       emp;
    logic       ful;
    logic       st;
    logic       bsy;
    logic [7:0] tx;
  } vec_t;

  vec_t tv[12];

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || !empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", busy || !empty, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_txin"}, txin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_tmo"}, tx_timeout, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         exp_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [9:0] got_bits, exp_bits;
  logic [7:0] exp_q[$];
  int         rate;

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;

    tv[0]  = '{1, 8'h11, 0, 1, 0, 0, 0, 0, 8'h00};
    tv[1]  = '{1, 8'h22, 0, 1, 0, 0, 1, 1, 8'h11};
    tv[2]  = '{1, 8'h33, 0, 2, 0, 0, 0, 1, 8'h11};
    tv[3]  = '{0, 8'h00, 1, 2, 0, 0, 0, 0, 8'h11};
    tv[4]  = '{0, 8'h00, 0, 1, 0, 0, 1, 1, 8'h22};
    tv[5]  = '{0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h22};
    tv[6]  = '{0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h22};
    tv[7]  = '{0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h22};
    tv[8]  = '{0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h33};
    tv[9]  = '{0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h33};
    tv[10] = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h33};
    tv[11] = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h33};
    for (int i = 0; i < 12; i++) begin
      wr_en = tv[i].we;
      wr_data = tv[i].d;
      td_man = tv[i].td;
      @(negedge clk);
      chk($sformatf("tv%0d_level", i), level, tv[i].lvl);
      chk($sformatf("tv%0d_empty", i), empty, tv[i].emp);
      chk($sformatf("tv%0d_full", i), full, tv[i].ful);
      chk($sformatf("tv%0d_start", i), start, tv[i].st);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("tv%0d_txin", i), txin, tv[i].tx);
    end
    wr_en = 1'b0;
    td_man = 1'b0;

    // single byte through the uart stand-in
    uart_on = 1'b1;
    bitc = 2;
    log_q.delete();
    wr_en = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("one_empty", empty, 0);
    chk("one_start_n1", start, 0);
    @(negedge clk);
    chk("one_start_n2", start, 1);
    chk("one_txin", txin, 8'hA5);
    chk("one_busy", busy, 1);
    @(negedge clk);
    chk("one_start_n3", start, 0);
    wait_idle(200);
    chk("one_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      got_bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) got_bits[k+1] = log_q[0][k];
      got_bits[9] = 1'b1;
      for (int k = 0; k < 10; k++) exp_bits[k] = exp_line[k][0];
      chk("one_line", got_bits, exp_bits);
    end

    // burst to full, then overflow, while a filler byte is in flight
    bitc = 3;
    log_q.delete();
    wr_en = 1'b1;
    wr_data = 8'h00;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      @(negedge clk);
      if (i == 2) gap_chk = 1'b1;
    end
    chk("burst_full", full, 1);
    chk("burst_level", level, 16);
    chk("burst_ovf0", overflow, 0);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    wait_idle(2000);
    gap_chk = 1'b0;
    chk("burst_count", log_q.size(), 17);
    for (int k = 0; k < log_q.size(); k++)
      chk($sformatf("burst_byte%0d", k), log_q[k], k);
    chk("ovf_sticky", overflow, 1);

    // simultaneous push and pop at level 3
    do_reset();
    uart_on = 1'b0;
    bitc = 1;
    log_q.delete();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("pp_level_a", level, 3);
    chk("pp_busy_a", busy, 1);
    td_man = 1'b1;
    @(negedge clk);
    td_man = 1'b0;
    chk("pp_idle", busy, 0);
    chk("pp_level_b", level, 3);
    uart_on = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hC5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pp_level_c", level, 3);
    chk("pp_start", start, 1);
    chk("pp_txin", txin, 8'hC2);
    wait_idle(1000);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    chk("pp_count", log_q.size(), 5);
    for (int k = 0; k < log_q.size() && k < 5; k++)
      chk($sformatf("pp_byte%0d", k), log_q[k], exp_q[k]);
    chk("pp_no_tmo", tx_timeout, 0);

    // stalled transmitter
    do_reset();
    uart_on = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    wr_data = 8'h66;
    @(negedge clk);
    wr_en = 1'b0;
    chk("to_start", start, 1);
    chk("to_txin", txin, 8'h55);
    repeat (TCYC) @(negedge clk);
    chk("to_early", tx_timeout, 0);
    chk("to_busy_early", busy, 1);
    @(negedge clk);
    chk("to_flag", tx_timeout, 1);
    chk("to_busy", busy, 0);
    @(negedge clk);
    chk("to_next_start", start, 1);
    chk("to_next_txin", txin, 8'h66);

    // asynchronous reset in the middle of WAIT_DONE
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the reference model
    rand_mode = 1'b1;
    uart_on = 1'b1;
    rate = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) rate = $urandom_range(1, 3);
      case (rate)
        1:       wr_en = ($urandom_range(0, 19) == 0);
        2:       wr_en = ($urandom_range(0, 1) == 0);
        default: wr_en = ($urandom_range(0, 9) != 0);
      endcase
      wr_data = 8'($urandom);
      @(negedge clk);
      chk("rnd_level", level, m_q.size());
      chk("rnd_empty", empty, m_q.size() == 0);
      chk("rnd_full", full, m_q.size() == DEPTH);
      chk("rnd_ovf", overflow, m_ovf);
      chk("rnd_tmo", tx_timeout, m_to);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_start", start, m_start);
      chk("rnd_txin", txin, m_txin);
    end
    wr_en = 1'b0;
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
